// File: rtl/phase_event_tracker_if.sv
// rtl/phase_event_tracker_if.sv - record output handshake between the tracker and its consumer
interface phase_event_tracker_if #(
   parameter int TAINT_W = 32,
   parameter int CYC_W   = 32,
   parameter int LANE_W  = 1
);
   logic               rec_valid;
   logic               rec_ready;
   logic [1:0]         rec_kind;
   logic [2:0]         rec_phase;
   logic [LANE_W-1:0]  rec_lane;
   logic [CYC_W-1:0]   rec_cycle;
   logic [CYC_W-1:0]   rec_dur;
   logic [TAINT_W-1:0] rec_taint_max;

   modport master (
      output rec_valid, rec_kind, rec_phase, rec_lane, rec_cycle, rec_dur, rec_taint_max,
      input  rec_ready
   );

   modport slave (
      input  rec_valid, rec_kind, rec_phase, rec_lane, rec_cycle, rec_dur, rec_taint_max,
      output rec_ready
   );
endinterface

// File: rtl/phase_event_tracker.sv
// rtl/phase_event_tracker.sv - decodes phase markers from commit lanes, tracks per-phase
// open/close state and taint maximum, and queues START/END/error records in a FIFO
module phase_event_tracker #(
   parameter int COMMIT_WIDTH = 2,
   parameter int FIFO_DEPTH   = 8,
   parameter int TAINT_W      = 32,
   parameter int CYC_W        = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [COMMIT_WIDTH-1:0]      commit_valid,
   input  logic [32*COMMIT_WIDTH-1:0]   commit_inst,
   input  logic [TAINT_W-1:0]           taint_sum,
   phase_event_tracker_if.master        rec,
   output logic [6:0]                   phase_active,
   output logic [15:0]                  drop_cnt,
   output logic                         overflow
);
   localparam int LANE_W  = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int MAX_REC = 2 * COMMIT_WIDTH;
   localparam int NREC_W  = $clog2(MAX_REC + 1);

   typedef enum logic [1:0] {K_START, K_END, K_NEST, K_ORPHAN} kind_e;
   typedef enum logic {IDLE, ACTIVE} pstate_e;

   typedef struct packed {
      kind_e              kind;
      logic [2:0]         phase;
      logic [LANE_W-1:0]  lane;
      logic [CYC_W-1:0]   cycle;
      logic [CYC_W-1:0]   dur;
      logic [TAINT_W-1:0] tmax;
   } rec_t;

   // Eight slots so a 3-bit phase index never leaves the array; slot 7 is unreachable.
   pstate_e            state_q [8];
   pstate_e            state_d [8];
   logic [CYC_W-1:0]   start_q [8];
   logic [CYC_W-1:0]   start_d [8];
   logic [TAINT_W-1:0] tmax_q  [8];
   logic [TAINT_W-1:0] tmax_d  [8];

   logic [CYC_W-1:0]   cyc;
   rec_t               recs [MAX_REC];
   logic [NREC_W-1:0]  nrec;
   logic [31:0]        inst;
   logic [2:0]         ph;

   rec_t               mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   wr_idx [MAX_REC];
   logic               space_ok, push, drop, pop;
   logic [16:0]        drop_sum;
   rec_t               head;

   // Lanes are walked in order against the running next-state, so later lanes
   // observe what earlier lanes did in the same cycle.
   always_comb begin
      state_d = state_q;
      start_d = start_q;
      for (int p = 0; p < 8; p++) begin
         tmax_d[p] = (state_q[p] == ACTIVE && taint_sum > tmax_q[p]) ? taint_sum : tmax_q[p];
      end
      for (int k = 0; k < MAX_REC; k++) begin
         recs[k] = '0;
      end
      nrec = '0;
      inst = '0;
      ph   = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         inst = commit_inst[32*i +: 32];
         ph   = inst[23:21];
         if (enable && commit_valid[i] && inst[19:0] == 20'h02013 &&
             inst[31:24] == 8'h00 && inst[23:20] <= 4'd13) begin
            if (!inst[20]) begin
               if (state_d[ph] == ACTIVE) begin
                  recs[nrec] = '{K_NEST, ph, LANE_W'(i), cyc, '0, taint_sum};
                  nrec       = nrec + 1'b1;
               end
               recs[nrec]  = '{K_START, ph, LANE_W'(i), cyc, '0, taint_sum};
               nrec        = nrec + 1'b1;
               state_d[ph] = ACTIVE;
               start_d[ph] = cyc;
               tmax_d[ph]  = taint_sum;
            end else if (state_d[ph] == ACTIVE) begin
               recs[nrec]  = '{K_END, ph, LANE_W'(i), cyc, cyc - start_d[ph], tmax_d[ph]};
               nrec        = nrec + 1'b1;
               state_d[ph] = IDLE;
            end else begin
               recs[nrec] = '{K_ORPHAN, ph, LANE_W'(i), cyc, '0, taint_sum};
               nrec       = nrec + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int p = 0; p < 8; p++) begin
            state_q[p] <= IDLE;
            start_q[p] <= '0;
            tmax_q[p]  <= '0;
         end
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         tmax_q  <= tmax_d;
      end
   end

   // Space is judged against occupancy before this cycle's pop, so a full FIFO
   // being drained still drops an incoming batch.
   always_comb begin
      space_ok = (FIFO_DEPTH - int'(count)) >= int'(nrec);
      push     = (nrec != '0) && space_ok;
      drop     = (nrec != '0) && !space_ok;
      pop      = (count != '0) && rec.rec_ready;
      drop_sum = {1'b0, drop_cnt} + 17'(nrec);
      for (int k = 0; k < MAX_REC; k++) begin
         wr_idx[k] = PTR_W'((int'(wr_ptr) + k) % FIFO_DEPTH);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cyc      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem[k] <= '0;
         end
      end else begin
         cyc <= cyc + 1'b1;
         if (push) begin
            for (int k = 0; k < MAX_REC; k++) begin
               if (k < int'(nrec)) begin
                  mem[wr_idx[k]] <= recs[k];
               end
            end
            wr_ptr <= PTR_W'((int'(wr_ptr) + int'(nrec)) % FIFO_DEPTH);
         end
         if (pop) begin
            rd_ptr <= PTR_W'((int'(rd_ptr) + 1) % FIFO_DEPTH);
         end
         count <= CNT_W'(int'(count) + (push ? int'(nrec) : 0) - (pop ? 1 : 0));
         if (drop) begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 7; p++) begin
         phase_active[p] = (state_q[p] == ACTIVE);
      end
   end

   assign head              = mem[rd_ptr];
   assign rec.rec_valid     = (count != '0);
   assign rec.rec_kind      = head.kind;
   assign rec.rec_phase     = head.phase;
   assign rec.rec_lane      = head.lane;
   assign rec.rec_cycle     = head.cycle;
   assign rec.rec_dur       = head.dur;
   assign rec.rec_taint_max = head.tmax;
endmodule

// File: tb/tb_phase_event_tracker.sv
// tb/tb_phase_event_tracker.sv - scoreboard bench for phase_event_tracker with a behavioural model
module tb_phase_event_tracker;
   localparam int DEPTH = 8;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [1:0]  commit_valid;
   logic [63:0] commit_inst;
   logic [31:0] taint_sum;
   logic [6:0]  phase_active;
   logic [15:0] drop_cnt;
   logic        overflow;

   phase_event_tracker_if #(.TAINT_W(32), .CYC_W(32), .LANE_W(1)) rif ();

   phase_event_tracker #(
      .COMMIT_WIDTH(2), .FIFO_DEPTH(DEPTH), .TAINT_W(32), .CYC_W(32)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .commit_valid(commit_valid), .commit_inst(commit_inst), .taint_sum(taint_sum),
      .rec(rif), .phase_active(phase_active), .drop_cnt(drop_cnt), .overflow(overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]  kind;
      logic [2:0]  phase;
      logic [0:0]  lane;
      logic [31:0] cycle;
      logic [31:0] dur;
      logic [31:0] tmax;
   } rec_t;

   rec_t        exp_q [$];
   bit   [6:0]  m_act;
   logic [31:0] m_start [7];
   logic [31:0] m_tmax  [7];
   logic [31:0] m_cyc;
   int          m_count;
   int          m_drop;
   bit          m_ovf;
   int          checks = 0;
   int          errors = 0;
   rec_t        mon_e, mon_a;

   function automatic rec_t mk(input int kind, input int ph, input int lane,
                               input logic [31:0] cyc, input logic [31:0] dur, input logic [31:0] tm);
      rec_t r;
      r.kind = 2'(kind); r.phase = 3'(ph); r.lane = 1'(lane);
      r.cycle = cyc; r.dur = dur; r.tmax = tm;
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Drives one cycle of stimulus, advances the model across the coming edge,
   // then checks the observable state #1 after that edge.
   task automatic step(input bit rst, input bit en, input logic [1:0] cv, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] taint, input bit rdy_in);
      rec_t        recs [$];
      bit   [6:0]  touched;
      logic [31:0] ins;
      int          ph;
      bit          pop;
      bit          rdy;
      rdy = rst ? 1'b0 : rdy_in;
      reset = rst; enable = en; commit_valid = cv; commit_inst = {i1, i0};
      taint_sum = taint; rif.rec_ready = rdy;
      touched = '0;
      if (rst) begin
         exp_q.delete();
         m_count = 0; m_drop = 0; m_ovf = 0; m_cyc = 0; m_act = '0;
         for (int p = 0; p < 7; p++) begin m_start[p] = 0; m_tmax[p] = 0; end
      end else begin
         for (int l = 0; l < 2; l++) begin
            ins = (l == 0) ? i0 : i1;
            if (en && cv[l] && ins[19:0] == 20'h02013 && ins[31:24] == 8'h00 && ins[23:20] <= 13) begin
               ph = int'(ins[23:21]);
               touched[ph] = 1'b1;
               if (ins[20] == 1'b0) begin
                  if (m_act[ph]) recs.push_back(mk(2, ph, l, m_cyc, 0, taint));
                  recs.push_back(mk(0, ph, l, m_cyc, 0, taint));
                  m_act[ph] = 1'b1; m_start[ph] = m_cyc; m_tmax[ph] = taint;
               end else if (m_act[ph]) begin
                  recs.push_back(mk(1, ph, l, m_cyc, m_cyc - m_start[ph],
                                    (taint > m_tmax[ph]) ? taint : m_tmax[ph]));
                  m_act[ph] = 1'b0;
               end else begin
                  recs.push_back(mk(3, ph, l, m_cyc, 0, taint));
               end
            end
         end
         for (int p = 0; p < 7; p++) begin
            if (m_act[p] && !touched[p] && taint > m_tmax[p]) m_tmax[p] = taint;
         end
         pop = (m_count > 0) && rdy;
         if (recs.size() > 0) begin
            if (DEPTH - m_count >= recs.size()) begin
               foreach (recs[k]) exp_q.push_back(recs[k]);
               m_count += recs.size();
            end else begin
               m_drop = (m_drop + recs.size() > 65535) ? 65535 : m_drop + recs.size();
               m_ovf  = 1'b1;
            end
         end
         if (pop) m_count--;
         m_cyc = m_cyc + 1;
      end
      @(posedge clock);
      #1;
      chk("phase_active", phase_active, m_act);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("overflow", overflow, m_ovf);
      chk("rec_valid", rif.rec_valid, m_count != 0);
   endtask

   task automatic idle_to(input logic [31:0] c, input logic [31:0] taint);
      for (int k = 0; k < 1000 && m_cyc != c; k++) step(0, 1, 2'b00, 0, 0, taint, 1);
   endtask

   function automatic logic [31:0] rand_inst();
      int r;
      logic [3:0] imm;
      r = $urandom_range(0, 9);
      imm = 4'($urandom_range(0, 15));
      if (r < 7) return {8'h00, imm, 20'h02013};
      if (r == 7) return {8'h01, imm, 20'h02013};
      return $urandom;
   endfunction

   always @(negedge clock) begin
      if (rif.rec_valid && rif.rec_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rec_unexpected kind=%0d phase=%0d cycle=%0d", rif.rec_kind, rif.rec_phase, rif.rec_cycle);
         end else begin
            mon_e = exp_q.pop_front();
            mon_a = '{rif.rec_kind, rif.rec_phase, rif.rec_lane, rif.rec_cycle, rif.rec_dur, rif.rec_taint_max};
            if (mon_e.kind == 2'd2) begin
               mon_a.dur = 0; mon_a.tmax = 0; mon_e.dur = 0; mon_e.tmax = 0;
            end
            checks++;
            if (mon_a != mon_e) begin
               errors++;
               $display("FAIL record actual kind=%0d ph=%0d lane=%0d cyc=%0d dur=%0d tmax=%0d expected kind=%0d ph=%0d lane=%0d cyc=%0d dur=%0d tmax=%0d",
                        mon_a.kind, mon_a.phase, mon_a.lane, mon_a.cycle, mon_a.dur, mon_a.tmax,
                        mon_e.kind, mon_e.phase, mon_e.lane, mon_e.cycle, mon_e.dur, mon_e.tmax);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; commit_valid = '0; commit_inst = '0; taint_sum = '0;
      rif.rec_ready = 1'b0;
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);

      // basic open/close on TEXE
      idle_to(10, 0);
      step(0, 1, 2'b01, 32'h00402013, 0, 5, 1);
      step(0, 1, 2'b00, 0, 0, 0, 1);
      step(0, 1, 2'b00, 0, 0, 9, 1);
      step(0, 1, 2'b00, 0, 0, 0, 1);
      step(0, 1, 2'b01, 32'h00502013, 0, 3, 1);

      // same-cycle START/END on LEAK
      idle_to(20, 1);
      step(0, 1, 2'b11, 32'h00602013, 32'h00702013, 7, 1);
      chk("leak_closed", phase_active[3], 0);

      // nesting and orphan
      step(1, 1, 0, 0, 0, 0, 0);
      idle_to(5, 2);
      step(0, 1, 2'b01, 32'h00002013, 0, 4, 1);
      idle_to(8, 2);
      step(0, 1, 2'b10, 0, 32'h00002013, 6, 1);
      idle_to(11, 3);
      step(0, 1, 2'b01, 32'h00102013, 0, 1, 1);
      step(0, 1, 2'b01, 32'h00302013, 0, 1, 1);
      for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0, 0, 1);

      // overflow with consumer stalled
      step(1, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++)
         step(0, 1, 2'b01, (k % 2 == 0) ? 32'h00202013 : 32'h00302013, 0, 32'(k), 0);
      chk("ovf_drop_cnt", drop_cnt, 1);
      chk("ovf_flag", overflow, 1);
      chk("ovf_active", phase_active, 7'b0000010);
      for (int k = 0; k < 12; k++) step(0, 1, 0, 0, 0, 0, 1);

      // reset mid-phase, then disabled marker
      step(0, 1, 2'b01, 32'h00c02013, 0, 11, 1);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("rst_active", phase_active, 0);
      chk("rst_valid", rif.rec_valid, 0);
      step(0, 0, 2'b01, 32'h00c02013, 0, 5, 1);
      chk("disabled_valid", rif.rec_valid, 0);
      step(0, 1, 2'b10, 0, 32'h00d02013, 5, 1);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 1);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 249) == 0, $urandom_range(0, 15) != 0, 2'($urandom_range(0, 3)),
              rand_inst(), rand_inst(),
              ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 255),
              $urandom_range(0, 3) != 0);
      end

      for (int k = 0; k < 100 && m_count != 0; k++) step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 1);
      chk("drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
